// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, size decode.
package lsu_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Ld  = 3'b011;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Lwu = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StBeat0,
        StWait0,
        StBeat1,
        StWait1,
        StResp
    } lsu_state_e;

    // Access size in bytes from funct3[1:0].
    function automatic logic [3:0] lsu_size(input logic [1:0] size_code);
        return 4'd1 << size_code;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane positioning for stores and merge/shift/extend for loads.
// With LSU_MISALIGN_EN the second-beat lanes and the split decision are provided.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [1:0]      size_i,
    input  logic [2:0]      offset_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata0_i,
`ifdef LSU_MISALIGN_EN
    input  logic [XLEN-1:0] rdata1_i,
    output logic [7:0]      be1_o,
    output logic [XLEN-1:0] wdata1_o,
    output logic            split_o,
`endif
    output logic [7:0]      be0_o,
    output logic [XLEN-1:0] wdata0_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]      mask;
    logic [5:0]      shamt;
    logic [XLEN-1:0] raw;

    assign mask  = 8'((16'd1 << lsu_size(size_i)) - 16'd1);
    assign shamt = {offset_i, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic [15:0]       be_full;
    logic [2*XLEN-1:0] wd_full;

    assign be_full  = {8'h00, mask} << offset_i;
    assign wd_full  = {{XLEN{1'b0}}, wdata_i} << shamt;
    assign be0_o    = be_full[7:0];
    assign be1_o    = be_full[15:8];
    assign wdata0_o = wd_full[XLEN-1:0];
    assign wdata1_o = wd_full[2*XLEN-1:XLEN];
    assign raw      = XLEN'({rdata1_i, rdata0_i} >> shamt);
    assign split_o  = ({2'b00, offset_i} + {1'b0, lsu_size(size_i)}) > 5'd8;
`else
    assign be0_o    = mask << offset_i;
    assign wdata0_o = wdata_i << shamt;
    assign raw      = rdata0_i >> shamt;
`endif

    always_comb begin
        rdata_o = raw;
        unique case (size_i)
            2'd0:    rdata_o = unsigned_i ? {56'b0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'd1:    rdata_o = unsigned_i ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    rdata_o = unsigned_i ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one transaction at a time on the data-memory port.
// LSU_MISALIGN_EN: allow misaligned accesses, splitting doubleword-crossing ones in two beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rdata0_q, rdata0_d;

    logic              req_fault;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        be0;
    logic [XLEN-1:0]   wd0;
    logic [XLEN-1:0]   ld_data;

`ifdef LSU_MISALIGN_EN
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [7:0]        be1;
    logic [XLEN-1:0]   wd1;
    logic              split;

    assign req_fault = 1'b0;
`else
    logic [3:0] req_size;

    assign req_size  = lsu_size(req_funct3[1:0]);
    assign req_fault = (req_addr[2:0] & 3'(req_size - 4'd1)) != 3'b000;
`endif

    assign base_addr = {addr_q[ADDR_W-1:3], 3'b000};

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .size_i     (f3_q[1:0]),
        .offset_i   (addr_q[2:0]),
        .unsigned_i (f3_q[2]),
        .wdata_i    (wdata_q),
        .rdata0_i   (rdata0_q),
`ifdef LSU_MISALIGN_EN
        .rdata1_i   (rdata1_q),
        .be1_o      (be1),
        .wdata1_o   (wd1),
        .split_o    (split),
`endif
        .be0_o      (be0),
        .wdata0_o   (wd0),
        .rdata_o    (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fault_d      = fault_q;
        rdata0_d     = rdata0_q;
`ifdef LSU_MISALIGN_EN
        rdata1_d     = rdata1_q;
`endif
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_misalign = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_be       = '0;
        mem_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    f3_d     = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    fault_d  = req_fault;
                    rdata0_d = '0;
`ifdef LSU_MISALIGN_EN
                    rdata1_d = '0;
`endif
                    state_d  = req_fault ? StResp : StBeat0;
                end
            end
            StBeat0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr;
                mem_be    = be0;
                mem_wdata = wd0;
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = StWait0;
`ifdef LSU_MISALIGN_EN
                    end else if (split) begin
                        state_d = StBeat1;
`endif
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait0: begin
                if (mem_rvalid) begin
                    rdata0_d = mem_rdata;
`ifdef LSU_MISALIGN_EN
                    state_d  = split ? StBeat1 : StResp;
`else
                    state_d  = StResp;
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            StBeat1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr + ADDR_W'(8);
                mem_be    = be1;
                mem_wdata = wd1;
                if (mem_gnt) begin
                    state_d = we_q ? StResp : StWait1;
                end
            end
            StWait1: begin
                if (mem_rvalid) begin
                    rdata1_d = mem_rdata;
                    state_d  = StResp;
                end
            end
`endif
            StResp: begin
                rsp_valid    = 1'b1;
                rsp_misalign = fault_q;
                rsp_rdata    = (we_q || fault_q) ? '0 : ld_data;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            rdata0_q <= '0;
`ifdef LSU_MISALIGN_EN
            rdata1_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            rdata0_q <= rdata0_d;
`ifdef LSU_MISALIGN_EN
            rdata1_q <= rdata1_d;
`endif
        end
    end

endmodule
